nios_mul_result_stage: RTL and testbench

//  Downstream of the CPU multiplier cell: consumes three registered 16x16 partial products
//  (lo*lo, lo*hi, hi*lo) and reduces them to the 32-bit low word of a 32x32 product.
//  Two-stage non-stalling reduction pipeline, then a small result FIFO with valid/ready

---
 rtl/nios_mul_pkg.sv | 19 +
 rtl/nios_mul_result_fifo.sv | 64 ++++++
 rtl/nios_mul_result_stage.sv | 113 +++++++++++
 tb/tb_nios_mul_result_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mul_pkg.sv
// Shared widths, types and pointer-width helper for the multiplier result stage.
package nios_mul_pkg;

  localparam int HALF_W   = 16;
  localparam int RESULT_W = 2 * HALF_W;

  typedef logic [RESULT_W-1:0] pp_t;
  typedef logic [RESULT_W-1:0] result_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_mul_result_fifo.sv
// Result FIFO: synchronous write, combinational head read, flush clears occupancy.
// Push into a full FIFO without a same-cycle pop is dropped and flagged by assertion.
module nios_mul_result_fifo
  import nios_mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RESULT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  input  logic                      flush,
  output logic [clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]          head
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  // A pop frees the head slot in the same edge, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/nios_mul_result_stage.sv
// Reduces three 16x16 partial products to the low 32-bit product word; 2-stage pipeline, then FIFO.
// Optional MUL_ACC_EN build accumulates results; in_ready is a credit covering in-flight and queued work.
module nios_mul_result_stage
  import nios_mul_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HALF_W     = nios_mul_pkg::HALF_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  pp_valid,
  input  logic [2*HALF_W-1:0]   pp1,
  input  logic [2*HALF_W-1:0]   pp2,
  input  logic [2*HALF_W-1:0]   pp3,
`ifdef MUL_ACC_EN
  input  logic                  acc_clr,
`endif
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*HALF_W-1:0]   out_data
);

  localparam int RW = 2 * HALF_W;
  localparam int AW = clog2(FIFO_DEPTH);

  logic              s1_v;
  logic [RW-1:0]     s1_p1;
  logic [HALF_W-1:0] s1_mid;
  logic              s2_v;
  logic [RW-1:0]     s2_prod;
  logic [HALF_W-1:0] mid;
  logic [RW-1:0]     prod;
  logic [RW-1:0]     stage2_result;
  logic [AW:0]       count;
  logic [RW-1:0]     head;
  logic [RW-1:0]     last_pop;
  logic [AW+1:0]     inflight;
  logic              unused_cross;

  // Cross-term bits above HALF_W land beyond the low result word.
  assign mid          = pp2[HALF_W-1:0] + pp3[HALF_W-1:0];
  assign unused_cross = ^{pp2[RW-1:HALF_W], pp3[RW-1:HALF_W]};
  assign prod         = s1_p1 + {s1_mid, {HALF_W{1'b0}}};

`ifdef MUL_ACC_EN
  logic          s1_clr;
  logic [RW-1:0] acc;

  assign stage2_result = (s1_clr ? '0 : acc) + prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_clr <= 1'b0;
      acc    <= '0;
    end else if (flush) begin
      s1_clr <= 1'b0;
      acc    <= '0;
    end else begin
      if (pp_valid) s1_clr <= acc_clr;
      if (s1_v)     acc    <= stage2_result;
    end
  end
`else
  assign stage2_result = prod;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_p1   <= '0;
      s1_mid  <= '0;
      s2_prod <= '0;
    end else begin
      s1_v <= pp_valid && !flush;
      s2_v <= s1_v && !flush;
      if (pp_valid) begin
        s1_p1  <= pp1;
        s1_mid <= mid;
      end
      if (s1_v) s2_prod <= stage2_result;
    end
  end

  nios_mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (s2_v),
    .din     (s2_prod),
    .pop     (out_ready),
    .flush   (flush),
    .count   (count),
    .head    (head)
  );

  // Credit counts everything that will eventually need a FIFO slot.
  assign inflight = (AW+2)'(count) + (AW+2)'(s1_v) + (AW+2)'(s2_v) + (AW+2)'(pp_valid);
  assign in_ready = inflight < (AW+2)'(FIFO_DEPTH);

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head : last_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              last_pop <= '0;
    else if (!flush && out_valid && out_ready) last_pop <= head;
  end

endmodule

// File: tb/tb_nios_mul_result_stage.sv
// Directed bench for nios_mul_result_stage: vector table plus credit, full-FIFO, flush and reset sequences.
module tb_nios_mul_result_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        pp_valid;
  logic [31:0] pp1;
  logic [31:0] pp2;
  logic [31:0] pp3;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef MUL_ACC_EN
  logic        acc_clr;
`endif

  int checks   = 0;
  int failures = 0;
  int issued;
  logic [31:0] expq[$];

  typedef struct {
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  nios_mul_result_stage #(.FIFO_DEPTH(4), .HALF_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .pp_valid  (pp_valid),
    .pp1       (pp1),
    .pp2       (pp2),
    .pp3       (pp3),
`ifdef MUL_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] exp, input string nm);
    pp1 = a; pp2 = b; pp3 = c; pp_valid = 1'b1;
    tick();
    pp_valid = 1'b0;
    chk({nm, "_valid_n0"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, "_valid_n1"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, "_valid_n2"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_empty"}, 32'(out_valid), 32'd0);
    chk({nm, "_hold"}, out_data, exp);
  endtask

  // Issue whenever the credit allows, with out_ready low; products equal pp1.
  task automatic fill(input logic [31:0] base);
    issued = 0;
    out_ready = 1'b0;
    pp2 = '0; pp3 = '0;
    for (int c = 0; c < 12; c++) begin
      pp_valid = 1'b0;
      #1;
      if (in_ready && issued < 8) begin
        pp1 = base + 32'(issued);
        pp_valid = 1'b1;
        issued++;
      end
      tick();
    end
    pp_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && expq.size() > 0; i++) begin
      chk($sformatf("%s_valid%0d", nm, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_data%0d", nm, i), out_data, expq[0]);
      void'(expq.pop_front());
      tick();
    end
    out_ready = 1'b0;
    chk({nm, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_2345, 32'h0000_2345, 32'h0000_0001, 32'h2346_2345};
    vecs[1] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 32'h0000_0001};
    vecs[2] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_0000};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2222_2222, 32'h4567_5678};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_FFFF};
    vecs[5] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};

    reset_n = 1'b0; flush = 1'b0; pp_valid = 1'b0; out_ready = 1'b0;
    pp1 = '0; pp2 = '0; pp3 = '0;
`ifdef MUL_ACC_EN
    acc_clr = 1'b1;
`endif
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      run_one(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].exp, $sformatf("vec%0d", i));

    // Credit limits the queue to exactly four results; drain keeps order.
    fill(32'h100);
    chk("fill_issued", 32'(issued), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    expq = '{32'h100, 32'h101, 32'h102, 32'h103};
    drain("fill_drain");

    // Push and pop on the same edge while full.
    fill(32'h200);
    pp_valid = 1'b0;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    pp1 = 32'h2FF; pp_valid = 1'b1;
    tick();
    pp_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop_in_ready", 32'(in_ready), 32'd0);
    chk("pushpop_head", out_data, 32'h201);
    expq = '{32'h201, 32'h202, 32'h203, 32'h2FF};
    drain("pushpop_drain");

    // Flush with two queued and two in flight, plus a discarded issue.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pp_valid = 1'b0;
      #1;
      chk($sformatf("flush_credit%0d", c), 32'(in_ready), 32'd1);
      pp1 = 32'h301 + 32'(c); pp_valid = 1'b1;
      tick();
    end
    flush = 1'b1; pp1 = 32'h3FF; pp_valid = 1'b1;
    tick();
    flush = 1'b0; pp_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_hold", out_data, 32'h2FF);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("flush_stale%0d", c), 32'(out_valid), 32'd0);
    end
    run_one(32'h1234, 32'h0, 32'h0, 32'h1234, "post_flush");

    // Reset mid-stream loses the in-flight result.
    pp1 = 32'h55; pp2 = '0; pp3 = '0; pp_valid = 1'b1;
    tick();
    pp_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midrst_stale%0d", c), 32'(out_valid), 32'd0);
    end

`ifdef MUL_ACC_EN
    acc_clr = 1'b1;
    run_one(32'd5, 32'd0, 32'd0, 32'd5, "acc_first");
    acc_clr = 1'b0;
    run_one(32'd7, 32'd0, 32'd0, 32'd12, "acc_sum");
    acc_clr = 1'b1;
    run_one(32'd9, 32'd0, 32'd0, 32'd9, "acc_reclr");
    acc_clr = 1'b0;
    run_one(32'd1, 32'd0, 32'd0, 32'd10, "acc_sum2");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_one(32'd3, 32'd0, 32'd0, 32'd3, "acc_after_rst");
    acc_clr = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
